// File: rtl/key_command_ctrl.sv
// Purpose: turns PS/2 scan-code bytes into Pac-Man direction commands, held-key map and pause strobes.
// Latency: 1 cycle from the code_valid byte that completes a sequence to the updated outputs.
// Backpressure: none on input; latest direction command is held pending until move_ack.
module key_command_ctrl #(
    parameter int PREFIX_TIMEOUT = 50000,
    parameter int TMO_W          = 16
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       move_ack,
    output logic [1:0] dir_code,
    output logic       dir_valid,
    output logic [3:0] held,
    output logic       pause_pulse,
    output logic       seq_error
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0]       CODE_E0  = 8'hE0;
    localparam logic [7:0]       CODE_F0  = 8'hF0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

    state_t           state;
    state_t           nxt_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             p_held;

    // Decoded key event for this cycle
    logic             ev_vld;
    logic             ev_ext;
    logic             ev_brk;
    logic             err_nxt;
    logic             key_dir_hit;
    logic [1:0]       key_dir;
    logic             key_pause;

    // Prefix state machine next-state and key-event extraction
    always_comb begin
        nxt_state = state;
        err_nxt   = 1'b0;
        ev_vld    = 1'b0;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code_in == CODE_E0)      nxt_state = GOT_E0;
                    else if (code_in == CODE_F0) nxt_state = GOT_F0;
                    else                         ev_vld    = 1'b1;
                end
                GOT_E0: begin
                    if (code_in == CODE_F0)      nxt_state = GOT_E0F0;
                    else if (code_in == CODE_E0) nxt_state = GOT_E0;
                    else begin
                        nxt_state = IDLE;
                        ev_vld    = 1'b1;
                        ev_ext    = 1'b1;
                    end
                end
                GOT_F0: begin
                    if (code_in == CODE_F0) nxt_state = GOT_F0;
                    else if (code_in == CODE_E0) begin
                        // E0 after F0 is out of order: resync onto the new prefix
                        nxt_state = GOT_E0;
                        err_nxt   = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        ev_vld    = 1'b1;
                        ev_brk    = 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    if (code_in == CODE_E0 || code_in == CODE_F0) begin
                        err_nxt = 1'b1;
                    end else begin
                        ev_vld = 1'b1;
                        ev_ext = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            nxt_state = IDLE;
            err_nxt   = 1'b1;
        end
    end

    // Key map lookup; unmapped codes (including E0 12 fake shift) produce no hit
    always_comb begin
        key_dir_hit = 1'b0;
        key_dir     = 2'd0;
        key_pause   = 1'b0;
        if (ev_vld) begin
            if (ev_ext) begin
                case (code_in)
                    8'h75:   begin key_dir_hit = 1'b1; key_dir = 2'd0; end
                    8'h72:   begin key_dir_hit = 1'b1; key_dir = 2'd1; end
                    8'h6B:   begin key_dir_hit = 1'b1; key_dir = 2'd2; end
                    8'h74:   begin key_dir_hit = 1'b1; key_dir = 2'd3; end
                    default: ;
                endcase
            end else begin
                case (code_in)
                    8'h1D:   begin key_dir_hit = 1'b1; key_dir = 2'd0; end
                    8'h1B:   begin key_dir_hit = 1'b1; key_dir = 2'd1; end
                    8'h1C:   begin key_dir_hit = 1'b1; key_dir = 2'd2; end
                    8'h23:   begin key_dir_hit = 1'b1; key_dir = 2'd3; end
                    8'h4D:   key_pause = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // State, timeout counter and registered command outputs
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            p_held      <= 1'b0;
            dir_code    <= 2'd0;
            dir_valid   <= 1'b0;
            held        <= 4'd0;
            pause_pulse <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= nxt_state;
            seq_error   <= err_nxt;
            pause_pulse <= 1'b0;

            if (code_valid || nxt_state == IDLE) tmo_cnt <= '0;
            else                                 tmo_cnt <= tmo_cnt + 1'b1;

            // Ack first so a same-cycle new command overrides it
            if (dir_valid && move_ack) dir_valid <= 1'b0;

            if (key_dir_hit) begin
                if (ev_brk) begin
                    held[key_dir] <= 1'b0;
                end else if (!held[key_dir]) begin
                    held[key_dir] <= 1'b1;
                    dir_code      <= key_dir;
                    dir_valid     <= 1'b1;
                end
            end

            if (key_pause) begin
                if (ev_brk) begin
                    p_held <= 1'b0;
                end else if (!p_held) begin
                    p_held      <= 1'b1;
                    pause_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_command_ctrl.sv
// Purpose: directed self-checking bench for key_command_ctrl.
// Latency: outputs sampled on the falling edge after the byte's capturing edge.
// Backpressure: not applicable; move_ack driven directly by the bench.
module tb_key_command_ctrl;

    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       move_ack = 1'b0;
    logic [1:0] dir_code;
    logic       dir_valid;
    logic [3:0] held;
    logic       pause_pulse;
    logic       seq_error;

    int n_chk  = 0;
    int n_fail = 0;

    int p_hi = 0, p_rise = 0, s_rise = 0;
    logic p_prev = 1'b0, s_prev = 1'b0;
    int base_hi, base_rise;

    key_command_ctrl #(.PREFIX_TIMEOUT(50000), .TMO_W(16)) dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .move_ack   (move_ack),
        .dir_code   (dir_code),
        .dir_valid  (dir_valid),
        .held       (held),
        .pause_pulse(pause_pulse),
        .seq_error  (seq_error)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Strobe counters sampled on the falling edge
    always @(negedge clk_50mhz) begin
        if (pause_pulse) p_hi++;
        if (pause_pulse && !p_prev) p_rise++;
        if (seq_error && !s_prev) s_rise++;
        p_prev = pause_pulse;
        s_prev = seq_error;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic ack);
        @(negedge clk_50mhz);
        code_in    = b;
        code_valid = 1'b1;
        move_ack   = ack;
        @(negedge clk_50mhz);
        code_valid = 1'b0;
        move_ack   = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk_50mhz);
        move_ack = 1'b1;
        @(negedge clk_50mhz);
        move_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_50mhz);
        reset = 1'b1;
        @(negedge clk_50mhz);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dir"},   8'(dir_code),    8'h0);
        chk({tag, "_vld"},   8'(dir_valid),   8'h0);
        chk({tag, "_held"},  8'(held),        8'h0);
        chk({tag, "_pause"}, 8'(pause_pulse), 8'h0);
        chk({tag, "_err"},   8'(seq_error),   8'h0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_reset_vals("rst");

        // Extended up arrow, then acknowledge
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        chk("up_dir",  8'(dir_code),  8'h0);
        chk("up_vld",  8'(dir_valid), 8'h1);
        chk("up_held", 8'(held),      8'h1);
        ack_pulse();
        chk("ack_vld", 8'(dir_valid), 8'h0);
        chk("ack_dir", 8'(dir_code),  8'h0);
        ack_pulse();
        chk("ack_idle_vld", 8'(dir_valid), 8'h0);

        // Typematic A: one command only, then break
        do_reset();
        send(8'h1C, 1'b0);
        chk("a_dir",  8'(dir_code),  8'h2);
        chk("a_vld",  8'(dir_valid), 8'h1);
        chk("a_held", 8'(held),      8'h4);
        ack_pulse();
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        chk("a_rep_vld",  8'(dir_valid), 8'h0);
        chk("a_rep_held", 8'(held),      8'h4);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        chk("a_brk_held", 8'(held),      8'h0);
        chk("a_brk_vld",  8'(dir_valid), 8'h0);
        chk("a_brk_dir",  8'(dir_code),  8'h2);

        // Latest wins, and new command beats a same-cycle ack
        do_reset();
        send(8'hE0, 1'b0);
        send(8'h74, 1'b0);
        chk("r_dir",  8'(dir_code), 8'h3);
        chk("r_held", 8'(held),     8'h8);
        send(8'h1B, 1'b0);
        chk("s_dir",  8'(dir_code),  8'h1);
        chk("s_held", 8'(held),      8'hA);
        chk("s_vld",  8'(dir_valid), 8'h1);
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b1);
        chk("l_ack_dir",  8'(dir_code),  8'h2);
        chk("l_ack_vld",  8'(dir_valid), 8'h1);
        chk("l_ack_held", 8'(held),      8'hE);
        send(8'hF0, 1'b0);
        send(8'h1B, 1'b0);
        chk("s_brk_held", 8'(held),      8'hC);
        chk("s_brk_vld",  8'(dir_valid), 8'h1);
        chk("s_brk_dir",  8'(dir_code),  8'h2);

        // Pause: two fresh presses, each strobe one cycle wide
        do_reset();
        base_hi   = p_hi;
        base_rise = p_rise;
        send(8'h4D, 1'b0);
        chk("p1", 8'(pause_pulse), 8'h1);
        send(8'h4D, 1'b0);
        chk("p_rep", 8'(pause_pulse), 8'h0);
        send(8'hF0, 1'b0);
        send(8'h4D, 1'b0);
        chk("p_brk", 8'(pause_pulse), 8'h0);
        send(8'h4D, 1'b0);
        chk("p2", 8'(pause_pulse), 8'h1);
        repeat (3) @(negedge clk_50mhz);
        chk("p_rises",  8'(p_rise - base_rise), 8'd2);
        chk("p_cycles", 8'(p_hi - base_hi),     8'd2);

        // Prefix timeout boundary
        do_reset();
        base_rise = s_rise;
        send(8'hE0, 1'b0);
        repeat (49999) @(negedge clk_50mhz);
        chk("tmo_early", 8'(seq_error), 8'h0);
        @(negedge clk_50mhz);
        chk("tmo_hit", 8'(seq_error), 8'h1);
        @(negedge clk_50mhz);
        chk("tmo_width", 8'(seq_error), 8'h0);
        chk("tmo_count", 8'(s_rise - base_rise), 8'd1);
        send(8'h75, 1'b0);
        chk("tmo_75_held", 8'(held),      8'h0);
        chk("tmo_75_vld",  8'(dir_valid), 8'h0);

        // Malformed F0 E0, then reset mid-sequence
        do_reset();
        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        chk("f0e0_err", 8'(seq_error), 8'h1);
        do_reset();
        chk_reset_vals("midrst");
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        chk("midrst_held", 8'(held),      8'h0);
        chk("midrst_err",  8'(seq_error), 8'h0);
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        chk("post_up_held", 8'(held), 8'h1);

        // Fake shift ignored; E0 F0 E0 is malformed
        send(8'hE0, 1'b0);
        send(8'h12, 1'b0);
        chk("fake_err",  8'(seq_error), 8'h0);
        chk("fake_held", 8'(held),      8'h1);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        chk("e0f0e0_err", 8'(seq_error), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
